// File: rtl/uart_tx_byte.sv
// UART byte transmitter: start bit, 8 data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit (even, or odd when PARITY_ODD=1).
module uart_tx_byte #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       start_i,
    input  logic [7:0] d_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       tx_o
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] TickLast = CntW'(OVERSAMPLE - 1);
    localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

    // Out-of-range configurations are rejected at elaboration time.
    if (OVERSAMPLE < 2 || OVERSAMPLE > 256) begin : g_bad_oversample
        $error("uart_tx_byte: OVERSAMPLE must be 2..256");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_byte: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_byte: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
    logic par_q;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state_q;
    logic [7:0]      shreg_q;
    logic [CntW-1:0] tick_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            tx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q == StIdle) begin
                if (start_i) begin
                    shreg_q    <= d_i;
                    tick_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    busy_q     <= 1'b1;
                    tx_q       <= 1'b0;
                    state_q    <= StStart;
`ifdef UART_TX_PARITY_EN
                    par_q      <= (^d_i) ^ (PARITY_ODD != 0);
`endif
                end
            end else if (tick_i) begin
                if (tick_cnt_q != TickLast) begin
                    tick_cnt_q <= tick_cnt_q + 1'b1;
                end else begin
                    // Bit boundary: tx_q takes the value of the bit that starts now.
                    tick_cnt_q <= '0;
                    case (state_q)
                        StStart: begin
                            state_q <= StData;
                            tx_q    <= shreg_q[0];
                        end
                        StData: begin
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                                state_q   <= StParity;
                                tx_q      <= par_q;
`else
                                state_q   <= StStop;
                                tx_q      <= 1'b1;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                shreg_q   <= shreg_q >> 1;
                                tx_q      <= shreg_q[1];
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        StParity: begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end
`endif
                        StStop: begin
                            if (bit_cnt_q == StopLast) begin
                                bit_cnt_q <= '0;
                                state_q   <= StIdle;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                        default: begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign tx_o   = tx_q;

endmodule
